rob_mp: RTL and testbench
=========================

// Module: rob_mp
// PURPOSE
//  Parametrised multi-port reorder buffer: N-wide in-order allocate, M writeback ports, K-wide in-order commit.
//  Adds a full/ready backpressure handshake and redirect-driven squash of younger entries.
//  Sits between rename/dispatch (enq side) and the rename free-list / arch map (commit side).
//  Execution units report completion through the writeback ports.
// PARAMETERS
//  DEPTH     32  entry count; power of 2, >= 2*ENQ_W
//  ENQ_W      2  allocate slots per cycle
//  CMT_W      2  commit slots per cycle
//  WB_PORTS   3  writeback ports
//  PC_W      64  pc width
//  LREG_W     5  logical reg index width
//  PREG_W     6  physical reg index width
//  (IDX_W = $clog2(DEPTH); robidx = {flag, idx})
// PORTS
//  clock            in   1                 clock
//  reset            in   1                 synchronous, active-high
//  enq_valid        in   ENQ_W             slot valids; contiguous from bit 0
//  enq_ready        out  1                 free entries >= ENQ_W
//  enq_instr        in   ENQ_W*32          per-slot instruction
//  enq_pc           in   ENQ_W*PC_W        per-slot pc
//  enq_lrd          in   ENQ_W*LREG_W      per-slot logical rd
//  enq_prd          in   ENQ_W*PREG_W      per-slot new physical rd
//  enq_old_prd      in   ENQ_W*PREG_W      per-slot previous mapping of lrd
//  enq_robidx_flag  out  1                 flag of slot 0 allocation; slot k = base+k
//  enq_robidx       out  IDX_W             idx of slot 0 allocation
//  wb_valid         in   WB_PORTS          completion strobes
//  wb_robidx_flag   in   WB_PORTS          completing entry flag
//  wb_robidx        in   WB_PORTS*IDX_W    completing entry idx
//  commit_valid     out  CMT_W             contiguous from bit 0
//  commit_instr     out  CMT_W*32          committed instruction
//  commit_pc        out  CMT_W*PC_W        committed pc
//  commit_lrd       out  CMT_W*LREG_W      committed logical rd
//  commit_prd       out  CMT_W*PREG_W      committed physical rd
//  commit_old_prd   out  CMT_W*PREG_W      register to free
//  redirect_valid   in   1                 squash request
//  redirect_robidx_flag in 1               redirecting entry flag
//  redirect_robidx  in   IDX_W             redirecting entry idx; entry itself survives
//  count            out  IDX_W+1           occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Per entry: valid, done, flag, instr, pc, lrd, prd, old_prd. Pointers enq_ptr/deq_ptr are IDX_W+1 bits.
//    MSB flips on wrap. count = enq_ptr - deq_ptr (mod 2^(IDX_W+1)).
//    Full when idx equal and flag differs; empty when pointers equal.
//  - Reset: all valid/done=0, both ptrs=0, count=0, commit_valid=0, enq_ready=1, enq_robidx/flag=0.
//  - Enq: accepted at clock edge when enq_ready & |enq_valid & ~redirect_valid. All-or-nothing per cycle.
//    Slot k is written to enq_ptr+k (mod DEPTH) with valid=1, done=0, flag=ptr MSB.
//    enq_ptr += popcount(enq_valid). enq_robidx is enq_ptr (combinational).
//    Enq while ~enq_ready is dropped; the source holds its data.
//  - Writeback: sets done=1 at next edge only if the entry is valid and the stored flag == wb flag.
//    Stale or mismatched writebacks are ignored. Multiple ports hitting the same entry is legal (OR).
//    Writeback to an entry allocated in the same cycle is ignored.
//  - Commit (combinational this cycle, pointer moves at edge): commit_valid[k]=1 iff entries deq_ptr+0..k
//    are all valid&done and k < count. Committed entries clear valid at edge. deq_ptr += popcount(commit_valid).
//    No commit past the oldest not-done entry.
//  - Redirect R: at edge, every entry strictly younger than R (age via flag/idx compare against deq_ptr)
//    clears valid/done, and enq_ptr := R+1. Same-cycle enq is blocked and same-cycle writeback to squashed
//    entries is ignored. Commits of entries older than or equal to R proceed normally in that cycle.
//    Redirect naming an invalid entry is illegal (assertion).
//  - Wrap: idx arithmetic mod DEPTH. Enq straddling the DEPTH-1 -> 0 boundary gives slot 1 the flipped flag.
//  - Simultaneous enq+commit when full: enq_ready uses pre-commit count (no bypass). 1-cycle bubble accepted.
//  - Reset mid-operation: all in-flight state is discarded next cycle; outputs return to reset values.
// TESTING
//  1. Reset, enq 2 (pc 0x80000000/4), wb both -> next cycle commit_valid=2'b11, count 2->0.
//  2. Enq idx0,1; wb idx1 only -> commit_valid=0; then wb idx0 -> commit_valid=2'b11 same cycle.
//  3. Fill to 32 -> enq_ready=0, count=32. Commit 2 -> enq_ready=1 following cycle, enq_ptr wraps with flag=1.
//  4. Stale wb: entry idx3 flag0 retired and reallocated with flag1; wb {0,3} -> done stays 0.
//  5. 10 in flight from idx0; redirect idx4 with enq_valid=2'b11 -> count=5, enq_robidx=5, enq dropped,
//     entries 5..9 never commit.
//  6. Assert reset with 8 entries live and wb pending -> next cycle count=0, commit_valid=0, enq_robidx=0.

Source files
------------

// File: rtl/rob_mp.sv
// Multi-port reorder buffer: in-order allocate and commit, out-of-order writeback,
// redirect squash of younger entries. Entries are named by {wrap flag, index}.
module rob_mp #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ENQ_W    = 2,
  parameter int unsigned CMT_W    = 2,
  parameter int unsigned WB_PORTS = 3,
  parameter int unsigned PC_W     = 64,
  parameter int unsigned LREG_W   = 5,
  parameter int unsigned PREG_W   = 6,
  localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ENQ_W-1:0]           enq_valid,
  output logic                       enq_ready,
  input  logic [ENQ_W*32-1:0]        enq_instr,
  input  logic [ENQ_W*PC_W-1:0]      enq_pc,
  input  logic [ENQ_W*LREG_W-1:0]    enq_lrd,
  input  logic [ENQ_W*PREG_W-1:0]    enq_prd,
  input  logic [ENQ_W*PREG_W-1:0]    enq_old_prd,
  output logic                       enq_robidx_flag,
  output logic [IDX_W-1:0]           enq_robidx,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS-1:0]        wb_robidx_flag,
  input  logic [WB_PORTS*IDX_W-1:0]  wb_robidx,
  output logic [CMT_W-1:0]           commit_valid,
  output logic [CMT_W*32-1:0]        commit_instr,
  output logic [CMT_W*PC_W-1:0]      commit_pc,
  output logic [CMT_W*LREG_W-1:0]    commit_lrd,
  output logic [CMT_W*PREG_W-1:0]    commit_prd,
  output logic [CMT_W*PREG_W-1:0]    commit_old_prd,
  input  logic                       redirect_valid,
  input  logic                       redirect_robidx_flag,
  input  logic [IDX_W-1:0]           redirect_robidx,
  output logic [IDX_W:0]             count
);

  typedef logic [IDX_W:0]   ptr_t;
  typedef logic [IDX_W-1:0] idx_t;

  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, flag_q;
  logic [31:0]       instr_q   [DEPTH];
  logic [PC_W-1:0]   pc_q      [DEPTH];
  logic [LREG_W-1:0] lrd_q     [DEPTH];
  logic [PREG_W-1:0] prd_q     [DEPTH];
  logic [PREG_W-1:0] old_prd_q [DEPTH];

  ptr_t enq_ptr_q, enq_ptr_d, deq_ptr_q, deq_ptr_d;
  ptr_t red_ptr, red_age, enq_cnt, cmt_cnt;
  ptr_t enq_slot [ENQ_W];
  idx_t cmt_idx  [CMT_W];
  logic enq_fire;

  assign count           = enq_ptr_q - deq_ptr_q;
  // No bypass: readiness is judged on the occupancy before this cycle's commits.
  assign enq_ready       = count <= ptr_t'(DEPTH - ENQ_W);
  assign enq_robidx_flag = enq_ptr_q[IDX_W];
  assign enq_robidx      = enq_ptr_q[IDX_W-1:0];
  assign red_ptr         = {redirect_robidx_flag, redirect_robidx};
  assign red_age         = red_ptr - deq_ptr_q;
  assign enq_fire        = enq_ready & (|enq_valid) & ~redirect_valid;

  always_comb begin
    enq_cnt = '0;
    for (int k = 0; k < ENQ_W; k++) begin
      enq_slot[k] = enq_ptr_q + ptr_t'(k);
      enq_cnt     = enq_cnt + ptr_t'(enq_valid[k]);
    end
  end

  // Commit stops at the first not-done entry and, under redirect, never passes it.
  always_comb begin
    logic run;
    run            = 1'b1;
    cmt_cnt        = '0;
    commit_valid   = '0;
    commit_instr   = '0;
    commit_pc      = '0;
    commit_lrd     = '0;
    commit_prd     = '0;
    commit_old_prd = '0;
    for (int k = 0; k < CMT_W; k++) begin
      cmt_idx[k] = deq_ptr_q[IDX_W-1:0] + idx_t'(k);
      run = run & valid_q[cmt_idx[k]] & done_q[cmt_idx[k]] & (ptr_t'(k) < count)
          & (~redirect_valid | (ptr_t'(k) <= red_age));
      commit_valid[k]                    = run;
      commit_instr[k*32 +: 32]           = instr_q[cmt_idx[k]];
      commit_pc[k*PC_W +: PC_W]          = pc_q[cmt_idx[k]];
      commit_lrd[k*LREG_W +: LREG_W]     = lrd_q[cmt_idx[k]];
      commit_prd[k*PREG_W +: PREG_W]     = prd_q[cmt_idx[k]];
      commit_old_prd[k*PREG_W +: PREG_W] = old_prd_q[cmt_idx[k]];
      cmt_cnt = cmt_cnt + ptr_t'(run);
    end
  end

  always_comb begin
    ptr_t age;
    valid_d = valid_q;
    done_d  = done_q;
    age     = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && valid_q[wb_robidx[p*IDX_W +: IDX_W]]
          && (flag_q[wb_robidx[p*IDX_W +: IDX_W]] == wb_robidx_flag[p])) begin
        done_d[wb_robidx[p*IDX_W +: IDX_W]] = 1'b1;
      end
    end
    for (int k = 0; k < CMT_W; k++) begin
      if (commit_valid[k]) begin
        valid_d[cmt_idx[k]] = 1'b0;
        done_d[cmt_idx[k]]  = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      age = {flag_q[i], idx_t'(i)} - deq_ptr_q;
      if (redirect_valid && (age > red_age)) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
    end
    if (enq_fire) begin
      for (int k = 0; k < ENQ_W; k++) begin
        if (enq_valid[k]) begin
          valid_d[enq_slot[k][IDX_W-1:0]] = 1'b1;
          done_d[enq_slot[k][IDX_W-1:0]]  = 1'b0;
        end
      end
    end
    deq_ptr_d = deq_ptr_q + cmt_cnt;
    if (redirect_valid) begin
      enq_ptr_d = red_ptr + ptr_t'(1);
    end else if (enq_fire) begin
      enq_ptr_d = enq_ptr_q + enq_cnt;
    end else begin
      enq_ptr_d = enq_ptr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      done_q    <= '0;
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
    end
  end

  // Payload needs no reset; valid_q gates every use of it.
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      for (int k = 0; k < ENQ_W; k++) begin
        if (enq_valid[k]) begin
          flag_q[enq_slot[k][IDX_W-1:0]]    <= enq_slot[k][IDX_W];
          instr_q[enq_slot[k][IDX_W-1:0]]   <= enq_instr[k*32 +: 32];
          pc_q[enq_slot[k][IDX_W-1:0]]      <= enq_pc[k*PC_W +: PC_W];
          lrd_q[enq_slot[k][IDX_W-1:0]]     <= enq_lrd[k*LREG_W +: LREG_W];
          prd_q[enq_slot[k][IDX_W-1:0]]     <= enq_prd[k*PREG_W +: PREG_W];
          old_prd_q[enq_slot[k][IDX_W-1:0]] <= enq_old_prd[k*PREG_W +: PREG_W];
        end
      end
    end
  end

  always @(posedge clock) begin
    if (!reset && redirect_valid) begin
      assert (valid_q[redirect_robidx] && (flag_q[redirect_robidx] == redirect_robidx_flag));
    end
  end

endmodule

// File: tb/tb_rob_mp.sv
// Directed bench for rob_mp: vector table for basic allocate/writeback/commit, plus
// hand sequences for full/wrap, stale writeback, redirect squash and mid-run reset.
module tb_rob_mp;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   enq_valid = '0;
  logic         enq_ready;
  logic [63:0]  enq_instr = '0;
  logic [127:0] enq_pc = '0;
  logic [9:0]   enq_lrd = '0;
  logic [11:0]  enq_prd = '0;
  logic [11:0]  enq_old_prd = '0;
  logic         enq_robidx_flag;
  logic [4:0]   enq_robidx;
  logic [2:0]   wb_valid = '0;
  logic [2:0]   wb_robidx_flag = '0;
  logic [14:0]  wb_robidx = '0;
  logic [1:0]   commit_valid;
  logic [63:0]  commit_instr;
  logic [127:0] commit_pc;
  logic [9:0]   commit_lrd;
  logic [11:0]  commit_prd;
  logic [11:0]  commit_old_prd;
  logic         redirect_valid = 1'b0;
  logic         redirect_robidx_flag = 1'b0;
  logic [4:0]   redirect_robidx = '0;
  logic [5:0]   count;

  always #5 clock = ~clock;

  rob_mp dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_instr(enq_instr), .enq_pc(enq_pc),
    .enq_lrd(enq_lrd), .enq_prd(enq_prd), .enq_old_prd(enq_old_prd),
    .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
    .wb_valid(wb_valid), .wb_robidx_flag(wb_robidx_flag), .wb_robidx(wb_robidx),
    .commit_valid(commit_valid), .commit_instr(commit_instr), .commit_pc(commit_pc),
    .commit_lrd(commit_lrd), .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .redirect_valid(redirect_valid), .redirect_robidx_flag(redirect_robidx_flag),
    .redirect_robidx(redirect_robidx), .count(count)
  );

  // One cycle of stimulus plus the outputs expected just before its clock edge.
  typedef struct {
    logic       rst;
    logic [1:0] ev;
    logic [2:0] wv;
    logic [5:0] w0, w1, w2;
    logic       rv;
    logic [5:0] rp;
    logic [1:0] cv;
    logic [5:0] cnt;
    logic       rdy;
    logic [5:0] ep;
  } vec_t;

  typedef struct {
    logic [5:0]  ptr;
    logic [63:0] pc;
    logic [42:0] meta;
    logic [5:0]  old;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;
  int   seq = 0;
  vec_t tbl [15];

  function automatic vec_t mk(int rst, int ev, int wv, int w0, int w1, int w2, int rv, int rp,
                              int cv, int cnt, int rdy, int ep);
    vec_t v;
    v.rst = 1'(rst); v.ev = 2'(ev); v.wv = 3'(wv);
    v.w0 = 6'(w0); v.w1 = 6'(w1); v.w2 = 6'(w2);
    v.rv = 1'(rv); v.rp = 6'(rp);
    v.cv = 2'(cv); v.cnt = 6'(cnt); v.rdy = 1'(rdy); v.ep = 6'(ep);
    return v;
  endfunction

  function automatic logic [63:0] pc_of(int n);
    return 64'h8000_0000 + 64'(4 * n);
  endfunction

  function automatic logic [42:0] meta_of(int n);
    return {32'h13 + 32'(n << 7), 5'(n), 6'(n + 1)};
  endfunction

  function automatic logic [5:0] old_of(int n);
    return 6'(n) ^ 6'h2a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL step %0d %s: got %0h, want %0h", step_no, name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    logic [5:0]  w [3];
    logic [42:0] m;
    int          keep;
    @(negedge clock);
    step_no++;
    w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
    reset          = v.rst;
    enq_valid      = v.ev;
    for (int k = 0; k < 2; k++) begin
      m = meta_of(seq + k);
      enq_instr[k*32 +: 32]  = m[42:11];
      enq_lrd[k*5 +: 5]      = m[10:6];
      enq_prd[k*6 +: 6]      = m[5:0];
      enq_pc[k*64 +: 64]     = pc_of(seq + k);
      enq_old_prd[k*6 +: 6]  = old_of(seq + k);
    end
    wb_valid = v.wv;
    for (int p = 0; p < 3; p++) begin
      wb_robidx_flag[p]     = w[p][5];
      wb_robidx[p*5 +: 5]   = w[p][4:0];
    end
    redirect_valid       = v.rv;
    redirect_robidx_flag = v.rp[5];
    redirect_robidx      = v.rp[4:0];
    #1;
    chk("commit_valid", 64'(commit_valid), 64'(v.cv));
    chk("count", 64'(count), 64'(v.cnt));
    chk("enq_ready", 64'(enq_ready), 64'(v.rdy));
    chk("enq_robidx", 64'({enq_robidx_flag, enq_robidx}), 64'(v.ep));
    for (int k = 0; k < 2; k++) begin
      if (v.cv[k]) begin
        if (mq.size() > k) begin
          chk("commit_pc", commit_pc[k*64 +: 64], mq[k].pc);
          chk("commit_meta", 64'({commit_instr[k*32 +: 32], commit_lrd[k*5 +: 5],
                                  commit_prd[k*6 +: 6]}), 64'(mq[k].meta));
          chk("commit_old_prd", 64'(commit_old_prd[k*6 +: 6]), 64'(mq[k].old));
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL step %0d model_empty: got commit slot %0d, want none", step_no, k);
        end
      end
    end
    @(posedge clock);
    if (v.rst) begin
      mq.delete();
    end else begin
      if (v.rv) begin
        keep = -1;
        foreach (mq[i]) if (mq[i].ptr == v.rp) keep = i;
        while (mq.size() > keep + 1) void'(mq.pop_back());
      end
      for (int k = 0; k < 2; k++) if (v.cv[k] && mq.size() > 0) void'(mq.pop_front());
      if (v.rdy && (|v.ev) && !v.rv) begin
        for (int k = 0; k < 2; k++) begin
          if (v.ev[k]) begin
            mq.push_back('{ptr: v.ep + 6'(k), pc: pc_of(seq), meta: meta_of(seq),
                           old: old_of(seq)});
            seq++;
          end
        end
      end
    end
  endtask

  task automatic hard_reset();
    @(negedge clock);
    reset = 1'b1; enq_valid = '0; wb_valid = '0; redirect_valid = 1'b0;
    @(posedge clock);
    mq.delete();
  endtask

  initial begin
    int cnt;
    int wv;
    int wi [3];
    // rst ev wv w0 w1 w2 rv rp | cv cnt rdy ep
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 3, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 3, 0, 1, 0,    0, 0, 0, 2, 1, 2);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,    0, 0, 3, 2, 1, 2);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 2);
    tbl[5]  = mk(0, 3, 0, 0, 0, 0,    0, 0, 0, 0, 1, 2);
    tbl[6]  = mk(0, 0, 1, 3, 0, 0,    0, 0, 0, 2, 1, 4);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 2, 1, 4);
    tbl[8]  = mk(0, 0, 1, 2, 0, 0,    0, 0, 0, 2, 1, 4);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,    0, 0, 3, 2, 1, 4);
    tbl[10] = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 4);
    tbl[11] = mk(0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 1, 4);
    tbl[12] = mk(0, 0, 7, 4, 4, 6'h24, 0, 0, 0, 1, 1, 5);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 1, 1, 5);
    tbl[14] = mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 5);

    repeat (2) @(posedge clock);
    foreach (tbl[i]) step(tbl[i]);

    // Fill from an odd pointer so the last pair straddles the wrap, then stale writeback.
    hard_reset();
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    for (int j = 0; j < 16; j++) step(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 2 * j, 1, 1 + 2 * j));
    step(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 32, 0, 33));
    step(mk(0, 0, 7, 0, 1, 2, 0, 0, 0, 32, 0, 33));
    step(mk(0, 3, 0, 0, 0, 0, 0, 0, 3, 32, 0, 33));
    step(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 30, 1, 33));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 0, 35));
    for (int c = 0; c < 10; c++) begin
      wv = 0;
      for (int p = 0; p < 3; p++) begin
        wi[p] = 3 + 3 * c + p;
        if (wi[p] <= 31) wv = wv | (1 << p);
        else wi[p] = 0;
      end
      cnt = (c == 0) ? 32 : 32 - 2 * (c - 1);
      step(mk(0, 0, wv, wi[0], wi[1], wi[2], 0, 0, (c == 0) ? 0 : 3, cnt, (cnt <= 30) ? 1 : 0,
              35));
    end
    for (int d = 0; d < 5; d++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 14 - 2 * d, 1, 35));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 35));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 35));
    step(mk(0, 0, 7, 32, 33, 34, 0, 0, 0, 3, 1, 35));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 1, 35));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 35));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 35));

    // Redirect at idx4 with 10 in flight and an enqueue attempt in the same cycle.
    hard_reset();
    for (int j = 0; j < 5; j++) step(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 2 * j, 1, 2 * j));
    step(mk(0, 0, 7, 1, 2, 3, 0, 0, 0, 10, 1, 10));
    step(mk(0, 0, 7, 4, 5, 6, 0, 0, 0, 10, 1, 10));
    step(mk(0, 0, 7, 7, 8, 9, 0, 0, 0, 10, 1, 10));
    step(mk(0, 3, 0, 0, 0, 0, 1, 4, 0, 10, 1, 10));
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 5));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 1, 5));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 1, 5));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));

    // Reset with 8 live entries and writebacks in flight.
    hard_reset();
    for (int j = 0; j < 4; j++) step(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 2 * j, 1, 2 * j));
    step(mk(1, 0, 3, 0, 1, 0, 0, 0, 0, 8, 1, 8));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
